// File: rtl/sensor_capture_pkg.sv
// Shared types and defaults for the sensor frame-capture sequencer.
// Optional continuous capture is controlled by SENSOR_CAPTURE_CONTINUOUS_EN in sensor_capture_ctrl.
package sensor_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  localparam int FRAME_LEN = 256;
  localparam int DATA_W    = 8;

  // Address width for a buffer of the given depth; at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/capture_frame_ram.sv
// Frame buffer: one write port and one registered read port, inferred as block RAM.
module capture_frame_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = sensor_capture_pkg::clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sensor_capture_ctrl.sv
// Captures FRAME_LEN synchronized sensor samples at a programmable rate, then streams them out.
// Define SENSOR_CAPTURE_CONTINUOUS_EN to keep capturing frames until a start pulse arrives during DRAIN.
module sensor_capture_ctrl #(
  parameter int FRAME_LEN = sensor_capture_pkg::FRAME_LEN,
  parameter int DATA_W    = sensor_capture_pkg::DATA_W,
  parameter int DIV_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [DATA_W-1:0] sens_data,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done
);
  import sensor_capture_pkg::*;

  localparam int AW = clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] sync_bits;
  logic [DIV_W-1:0]  div_reg, cnt_reg;
  logic [AW-1:0]     wr_addr_reg, rd_addr_reg, rd_idx_reg;
  logic              rd_vld_reg, rd_all_reg;
  logic              out_valid_reg, out_last_reg;
  logic [DATA_W-1:0] out_data_reg, rd_data;
  logic              tick, advance, rd_en, last_hs;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sync
    logic meta_reg, sync_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= sens_data[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_bits[gi] = sync_reg;
  end

  assign tick    = (state_reg == CAPTURE) && (cnt_reg == '0);
  assign advance = !out_valid_reg || out_ready;
  assign rd_en   = (state_reg == DRAIN) && advance && !rd_all_reg;
  assign last_hs = (state_reg == DRAIN) && out_valid_reg && out_ready && out_last_reg;

`ifdef SENSOR_CAPTURE_CONTINUOUS_EN
  logic stop_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stop_reg <= 1'b0;
    else if (state_reg == IDLE) stop_reg <= 1'b0;
    else if (state_reg == DRAIN && start) stop_reg <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = CAPTURE;
      CAPTURE: begin
        busy = 1'b1;
        if (tick && wr_addr_reg == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_hs) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
`ifdef SENSOR_CAPTURE_CONTINUOUS_EN
        busy       = !stop_reg;
        state_next = stop_reg ? IDLE : CAPTURE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider and write address; DONE pre-loads the divider for a back-to-back frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg     <= '0;
      cnt_reg     <= '0;
      wr_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          div_reg     <= sample_div;
          cnt_reg     <= sample_div;
          wr_addr_reg <= '0;
        end
        CAPTURE: begin
          if (tick) begin
            cnt_reg     <= div_reg;
            wr_addr_reg <= wr_addr_reg + AW'(1);
          end else begin
            cnt_reg <= cnt_reg - DIV_W'(1);
          end
        end
        DONE: begin
          cnt_reg     <= div_reg;
          wr_addr_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // Two-stage read pipeline (RAM register, output register) that freezes as a unit on backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_reg   <= '0;
      rd_idx_reg    <= '0;
      rd_vld_reg    <= 1'b0;
      rd_all_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (state_reg != DRAIN) begin
      rd_addr_reg   <= '0;
      rd_vld_reg    <= 1'b0;
      rd_all_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= rd_vld_reg;
      out_last_reg  <= rd_vld_reg && (rd_idx_reg == LAST_ADDR);
      if (rd_vld_reg) out_data_reg <= rd_data;
      rd_vld_reg <= !rd_all_reg;
      if (!rd_all_reg) begin
        rd_idx_reg  <= rd_addr_reg;
        rd_addr_reg <= rd_addr_reg + AW'(1);
        rd_all_reg  <= (rd_addr_reg == LAST_ADDR);
      end
    end
  end

  capture_frame_ram #(
    .DEPTH (FRAME_LEN),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (tick),
    .wr_addr(wr_addr_reg),
    .wr_data(sync_bits),
    .rd_en  (rd_en),
    .rd_addr(rd_addr_reg),
    .rd_data(rd_data)
  );

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_sensor_capture_ctrl.sv
// Scoreboard bench for sensor_capture_ctrl: the sensor pin sequence is pre-drawn, so every
// expected frame is derived from the capture schedule (tick edges) when start is issued.
`timescale 1ns/1ps
module tb_sensor_capture_ctrl;

  localparam int N_SAMP = 256;
  localparam int HMASK  = 16383;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] sample_div = '0;
  logic [7:0]  sens_data = '0;
  logic        busy, out_valid, out_last, frame_done;
  logic [7:0]  out_data;

  sensor_capture_ctrl #(.FRAME_LEN(N_SAMP), .DATA_W(8), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_div(sample_div),
    .sens_data(sens_data), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int edge_cnt = 0;
  int done_cnt = 0, hs_cnt = 0, exp_frames = 0;
  int cont_left = 0, cur_div = 0, ready_mode = 0;

  // hist[e] is the pin value the DUT samples at rising edge number e
  logic [7:0] hist [0:HMASK];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Start accepted at edge n: ticks at n+1+div+i*(div+1), each writing the pin value from 2 edges earlier.
  task automatic push_frame(input int n, input int div);
    exp_t e;
    for (int i = 0; i < N_SAMP; i++) begin
      e.data = hist[(n - 1 + div + i * (div + 1)) & HMASK];
      e.last = (i == N_SAMP - 1);
      exp_q.push_back(e);
    end
    exp_frames++;
    $display("issue frame %0d: start edge=%0d div=%0d", exp_frames, n, div);
  endtask

  // Caller is positioned 1ns after a rising edge.
  task automatic start_frame(input int div);
    sample_div = 16'(div);
    cur_div = div;
    start = 1'b1;
    push_frame(edge_cnt + 1, div);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    sample_div = 16'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_timeout", int'(done_cnt >= target), 1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  // Pin and consumer driver
  initial begin
    for (int i = 0; i <= HMASK; i++) hist[i] = 8'($urandom);
    sens_data = hist[1];
    forever begin
      @(posedge clk); #1;
      sens_data = hist[(edge_cnt + 1) & HMASK];
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((edge_cnt % 4) == 0) || ((edge_cnt % 4) == 3);
        default: out_ready = 1'($urandom);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake
  initial begin
    logic       prev_stall, prev_last, done_due;
    logic [7:0] prev_data;
    exp_t       e;
    prev_stall = 1'b0;
    prev_last  = 1'b0;
    prev_data  = '0;
    done_due   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        done_due   = 1'b0;
      end else begin
        if (frame_done) done_cnt++;
        if (done_due) begin
          chk("frame_done_after_last", int'(frame_done), 1);
          chk("busy_at_done", int'(busy), int'(cont_left > 0));
          $display("frame_done seen: count=%0d busy=%0b", done_cnt, busy);
          if (cont_left > 0) begin
            push_frame(edge_cnt + 1, cur_div);
            cont_left--;
          end
          done_due = 1'b0;
        end
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), int'(prev_data));
          chk("stall_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got data %0d with no sample expected", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("data", int'(out_data), int'(e.data));
            chk("last", int'(out_last), int'(e.last));
            if (e.last) done_due = 1'b1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

`ifndef SENSOR_CAPTURE_CONTINUOUS_EN
    // Full-rate ramp from 0x00
    ready_mode = 0;
    base = edge_cnt + 4;
    for (int k = 0; k < 300; k++) hist[(base + k) & HMASK] = 8'(k);
    while (edge_cnt < base) begin
      @(posedge clk); #1;
    end
    start_frame(0);
    wait_frames(exp_frames, 2000);

    // Divided rate, restarted in the cycle right after frame_done
    start_frame(3);
    wait_frames(exp_frames, 3000);

    // Backpressure 1,0,0,1
    ready_mode = 1;
    start_frame(0);
    wait_frames(exp_frames, 3000);

    // Random rate and random consumer
    ready_mode = 2;
    for (int r = 0; r < 2; r++) begin
      start_frame(int'($urandom_range(0, 2)));
      wait_frames(exp_frames, 4000);
    end

    // Start pulses while busy are ignored
    ready_mode = 2;
    start_frame(1);
    repeat (100) @(posedge clk);
    #1;
    pulse_start();
    wait_valid(2000);
    pulse_start();
    wait_frames(exp_frames, 3000);
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_busy", int'(busy), 0);
    chk("ignored_start_frames", done_cnt, exp_frames);
`endif

    // Reset asserted mid-capture at wr_addr=100
    ready_mode = 0;
    @(posedge clk); #1;
    sample_div = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_last", int'(out_last), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    chk("abort_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    chk("abort_busy_after", int'(busy), 0);
    chk("abort_no_frame_done", done_cnt, exp_frames);

`ifdef SENSOR_CAPTURE_CONTINUOUS_EN
    // Continuous: stop request during the second DRAIN ends capture after two frames
    ready_mode = 0;
    cont_left = 1;
    base = exp_frames + 2;
    start_frame(1);
    wait_frames(base - 1, 3000);
    wait_valid(2000);
    pulse_start();
    wait_frames(base, 3000);
    repeat (50) @(posedge clk);
    #1;
    chk("continuous_busy_after", int'(busy), 0);
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("frames_total", done_cnt, exp_frames);
    chk("handshakes_total", hs_cnt, exp_frames * N_SAMP);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
